lcd_hd44780_responder: RTL and testbench

//  Receiving end of the 8-bit HD44780-style character-LCD bus (E/RS/RW/DATA) driven by our text-LCD writers.

---
 rtl/lcd_pkg.sv | 113 +++++++++++
 rtl/lcd_ddram.sv | 34 +++
 rtl/lcd_hd44780_responder.sv | 259 +++++++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-style character-LCD bus: instruction
// opcode masks, blank character code, DDRAM line geometry and the address
// counter helpers (validity, linear index, wrap-aware step). Used by the
// responder and by the text-LCD writer blocks.
// ---------------------------------------------------------------------------
package lcd_pkg;

    // Instruction opcodes, identified by their highest set bit
    localparam logic [7:0] OP_SET_DDRAM = 8'h80;
    localparam logic [7:0] OP_SET_CGRAM = 8'h40;
    localparam logic [7:0] OP_FUNC_SET  = 8'h20;
    localparam logic [7:0] OP_SHIFT     = 8'h10;
    localparam logic [7:0] OP_DISP_CTRL = 8'h08;
    localparam logic [7:0] OP_ENTRY     = 8'h04;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_CLEAR     = 8'h01;

    localparam logic [7:0] BLANK_CHAR    = 8'h20;
    localparam logic [6:0] LINE0_BASE    = 7'h00;
    localparam logic [6:0] LINE1_BASE    = 7'h40;
    localparam logic [6:0] LINE0_LAST    = 7'h27;
    localparam logic [6:0] LINE1_LAST    = 7'h67;
    localparam logic [6:0] ONE_LINE_LAST = 7'h4F;
    localparam int         LINE_LEN      = 40;
    localparam int         DDRAM_DEPTH   = 80;

    typedef enum logic [3:0] {
        INSTR_NONE  = 4'd0,
        INSTR_CLEAR = 4'd1,
        INSTR_HOME  = 4'd2,
        INSTR_ENTRY = 4'd3,
        INSTR_DISP  = 4'd4,
        INSTR_SHIFT = 4'd5,
        INSTR_FUNC  = 4'd6,
        INSTR_CGRAM = 4'd7,
        INSTR_DDRAM = 4'd8
    } instr_t;

    typedef enum logic [1:0] {
        INIT_CLR = 2'd0,
        IDLE     = 2'd1,
        CLR_FILL = 2'd2
    } clr_state_t;

    // Display configuration bits held by the controller
    typedef struct packed {
        logic id;   // entry mode: 1 = increment
        logic s;    // entry mode: display shift (stored only)
        logic dl;   // function set: 8-bit interface (stored only)
        logic f;    // function set: font (stored only)
        logic n;    // function set: two-line mode
        logic d;    // display on
        logic c;    // cursor on (stored only)
        logic b;    // blink on (stored only)
    } lcd_cfg_t;

    function automatic instr_t instr_decode(input logic [7:0] op);
        instr_t r;
        if ((op & OP_SET_DDRAM) != 8'h00)      r = INSTR_DDRAM;
        else if ((op & OP_SET_CGRAM) != 8'h00) r = INSTR_CGRAM;
        else if ((op & OP_FUNC_SET) != 8'h00)  r = INSTR_FUNC;
        else if ((op & OP_SHIFT) != 8'h00)     r = INSTR_SHIFT;
        else if ((op & OP_DISP_CTRL) != 8'h00) r = INSTR_DISP;
        else if ((op & OP_ENTRY) != 8'h00)     r = INSTR_ENTRY;
        else if ((op & OP_HOME) != 8'h00)      r = INSTR_HOME;
        else if ((op & OP_CLEAR) != 8'h00)     r = INSTR_CLEAR;
        else                                   r = INSTR_NONE;
        return r;
    endfunction

    function automatic logic ac_valid(input logic [6:0] a, input logic two_line);
        logic r;
        if (two_line) r = (a <= LINE0_LAST) || ((a >= LINE1_BASE) && (a <= LINE1_LAST));
        else          r = (a <= ONE_LINE_LAST);
        return r;
    endfunction

    // Second line is stored directly after the first in the linear image
    function automatic logic [6:0] ac_index(input logic [6:0] a, input logic two_line);
        logic [6:0] r;
        if (two_line && (a >= LINE1_BASE)) r = a - LINE1_BASE + 7'(LINE_LEN);
        else                               r = a;
        return r;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc,
                                           input logic two_line);
        logic [6:0] r;
        if (two_line) begin
            if (inc) begin
                if (a == LINE0_LAST)      r = LINE1_BASE;
                else if (a == LINE1_LAST) r = LINE0_BASE;
                else                      r = a + 7'd1;
            end else begin
                if (a == LINE1_BASE)      r = LINE0_LAST;
                else if (a == LINE0_BASE) r = LINE1_LAST;
                else                      r = a - 7'd1;
            end
        end else begin
            if (inc) begin
                if (a >= ONE_LINE_LAST)   r = LINE0_BASE;
                else                      r = a + 7'd1;
            end else begin
                if (a == LINE0_BASE)      r = ONE_LINE_LAST;
                else                      r = a - 7'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// ---------------------------------------------------------------------------
// lcd_ddram
// 80x8 display data RAM: one synchronous write port, two asynchronous read
// ports (bus read and display view). Out-of-range reads return 8'h00 and
// out-of-range writes are ignored.
// Ports: clk, we/waddr/wdata (write), raddr_a/rdata_a (bus),
//        raddr_b/rdata_b (view).
// ---------------------------------------------------------------------------
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [6:0] raddr_b,
    output logic [7:0] rdata_b
);

    logic [7:0] mem_r [0:DDRAM_DEPTH-1];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we && (waddr < 7'(DDRAM_DEPTH))) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a < 7'(DDRAM_DEPTH)) ? mem_r[raddr_a] : 8'h00;
    assign rdata_b = (raddr_b < 7'(DDRAM_DEPTH)) ? mem_r[raddr_b] : 8'h00;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_responder
// Receiving end of an 8-bit HD44780-style LCD bus. Synchronizes E/RS/RW/DIN,
// commits a transaction after each E falling edge, decodes instructions,
// keeps the DDRAM image, address counter, display config and busy flag, and
// answers status/data read cycles.
// Ports: clk, rst (async active-low); LCD_E/LCD_RS/LCD_RW/LCD_DIN bus in;
//        LCD_DOUT/LCD_DOE bus read data; busy, ac, disp_on, two_line, err
//        status; view_addr -> view_char combinational display view.
// ---------------------------------------------------------------------------
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYC     = 40,
    parameter int CLR_BUSY_CYC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DIN,
    output logic [7:0] LCD_DOUT,
    output logic       LCD_DOE,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       two_line,
    output logic       err,
    input  logic [6:0] view_addr,
    output logic [7:0] view_char
);

    localparam int                CNT_W     = $clog2(CLR_BUSY_CYC + BUSY_CYC + 1);
    localparam logic [CNT_W-1:0]  BUSY_LOAD = CNT_W'(BUSY_CYC);
    localparam logic [CNT_W-1:0]  CLR_LOAD  = CNT_W'(CLR_BUSY_CYC);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [6:0]        FILL_LAST = 7'(DDRAM_DEPTH - 1);
    localparam lcd_cfg_t          CFG_RESET = '{id: 1'b1, s: 1'b0, dl: 1'b1, f: 1'b0,
                                                n: 1'b0, d: 1'b0, c: 1'b0, b: 1'b0};

    logic        e_meta_r, e_sync_r, e_prev_r;
    logic        rs_meta_r, rs_sync_r, rw_meta_r, rw_sync_r;
    logic [7:0]  din_meta_r, din_sync_r;
    logic        rs_lat_r, rw_lat_r;
    logic [7:0]  din_lat_r;

    clr_state_t  state_r, state_nxt_s;
    logic [6:0]  fill_idx_r, fill_idx_nxt_s;
    logic [6:0]  ac_r, ac_nxt_s;
    lcd_cfg_t    cfg_r, cfg_nxt_s;
    logic        err_r, err_nxt_s;
    logic [CNT_W-1:0] busy_cnt_r, busy_cnt_nxt_s;
    logic        busy_r;
    logic        doe_r, doe_nxt_s;
    logic [7:0]  dout_r, dout_nxt_s;

    logic        fall_s, wr_s, rd_step_s;
    instr_t      instr_s;
    logic        mem_we_s;
    logic [6:0]  mem_waddr_s;
    logic [7:0]  mem_wdata_s;
    logic [7:0]  bus_rdata_s;

    // Two-flop synchronizers, E edge history and last-E-high bus capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_meta_r   <= 1'b0;
            e_sync_r   <= 1'b0;
            e_prev_r   <= 1'b0;
            rs_meta_r  <= 1'b0;
            rs_sync_r  <= 1'b0;
            rw_meta_r  <= 1'b0;
            rw_sync_r  <= 1'b0;
            din_meta_r <= 8'h00;
            din_sync_r <= 8'h00;
            rs_lat_r   <= 1'b0;
            rw_lat_r   <= 1'b0;
            din_lat_r  <= 8'h00;
        end else begin
            e_meta_r   <= LCD_E;
            e_sync_r   <= e_meta_r;
            e_prev_r   <= e_sync_r;
            rs_meta_r  <= LCD_RS;
            rs_sync_r  <= rs_meta_r;
            rw_meta_r  <= LCD_RW;
            rw_sync_r  <= rw_meta_r;
            din_meta_r <= LCD_DIN;
            din_sync_r <= din_meta_r;
            if (e_sync_r) begin
                rs_lat_r  <= rs_sync_r;
                rw_lat_r  <= rw_sync_r;
                din_lat_r <= din_sync_r;
            end
        end
    end

    assign fall_s    = e_prev_r & ~e_sync_r;
    assign wr_s      = fall_s & ~rw_lat_r;
    assign rd_step_s = fall_s & rw_lat_r & rs_lat_r;
    assign instr_s   = instr_decode(din_lat_r);

    // Controller state registers; reset starts the power-on clear with busy held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= INIT_CLR;
            fill_idx_r <= 7'd0;
            ac_r       <= 7'd0;
            cfg_r      <= CFG_RESET;
            err_r      <= 1'b0;
            busy_cnt_r <= CLR_LOAD;
            busy_r     <= 1'b1;
            doe_r      <= 1'b0;
            dout_r     <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            fill_idx_r <= fill_idx_nxt_s;
            ac_r       <= ac_nxt_s;
            cfg_r      <= cfg_nxt_s;
            err_r      <= err_nxt_s;
            busy_cnt_r <= busy_cnt_nxt_s;
            busy_r     <= (busy_cnt_nxt_s != CNT_ZERO);
            doe_r      <= doe_nxt_s;
            dout_r     <= dout_nxt_s;
        end
    end

    // Clear sequencer, instruction/data decode, AC stepping and busy counter
    always_comb begin
        state_nxt_s    = state_r;
        fill_idx_nxt_s = fill_idx_r;
        ac_nxt_s       = ac_r;
        cfg_nxt_s      = cfg_r;
        err_nxt_s      = err_r;
        busy_cnt_nxt_s = (busy_cnt_r != CNT_ZERO) ? (busy_cnt_r - CNT_ONE) : CNT_ZERO;
        mem_we_s       = 1'b0;
        mem_waddr_s    = 7'd0;
        mem_wdata_s    = 8'h00;

        // The fill always finishes inside the busy window, so it never
        // competes with a bus write for the single write port.
        case (state_r)
            INIT_CLR, CLR_FILL: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = fill_idx_r;
                mem_wdata_s = BLANK_CHAR;
                if (fill_idx_r == FILL_LAST) begin
                    state_nxt_s    = IDLE;
                    fill_idx_nxt_s = 7'd0;
                end else begin
                    fill_idx_nxt_s = fill_idx_r + 7'd1;
                end
            end
            IDLE: begin
                fill_idx_nxt_s = 7'd0;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (wr_s) begin
            if (busy_r) begin
                err_nxt_s = 1'b1;
            end else begin
                busy_cnt_nxt_s = BUSY_LOAD;
                if (rs_lat_r) begin
                    if (ac_valid(ac_r, cfg_r.n)) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = ac_index(ac_r, cfg_r.n);
                        mem_wdata_s = din_lat_r;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                    ac_nxt_s = ac_step(ac_r, cfg_r.id, cfg_r.n);
                end else begin
                    case (instr_s)
                        INSTR_DDRAM: begin
                            if (ac_valid(din_lat_r[6:0], cfg_r.n)) ac_nxt_s  = din_lat_r[6:0];
                            else                                   err_nxt_s = 1'b1;
                        end
                        INSTR_CGRAM: begin
                            ac_nxt_s = ac_r;
                        end
                        INSTR_FUNC: begin
                            cfg_nxt_s.dl = din_lat_r[4];
                            cfg_nxt_s.n  = din_lat_r[3];
                            cfg_nxt_s.f  = din_lat_r[2];
                        end
                        INSTR_SHIFT: begin
                            // Only cursor moves touch AC; display shift has no view effect
                            if (!din_lat_r[3]) ac_nxt_s = ac_step(ac_r, din_lat_r[2], cfg_r.n);
                            else               ac_nxt_s = ac_r;
                        end
                        INSTR_DISP: begin
                            cfg_nxt_s.d = din_lat_r[2];
                            cfg_nxt_s.c = din_lat_r[1];
                            cfg_nxt_s.b = din_lat_r[0];
                        end
                        INSTR_ENTRY: begin
                            cfg_nxt_s.id = din_lat_r[1];
                            cfg_nxt_s.s  = din_lat_r[0];
                        end
                        INSTR_HOME: begin
                            ac_nxt_s = 7'd0;
                        end
                        INSTR_CLEAR: begin
                            state_nxt_s    = CLR_FILL;
                            fill_idx_nxt_s = 7'd0;
                            busy_cnt_nxt_s = CLR_LOAD;
                            ac_nxt_s       = 7'd0;
                            cfg_nxt_s.id   = 1'b1;
                        end
                        default: begin
                            ac_nxt_s = ac_r;
                        end
                    endcase
                end
            end
        end else if (rd_step_s) begin
            ac_nxt_s = ac_step(ac_r, cfg_r.id, cfg_r.n);
        end else begin
            ac_nxt_s = ac_r;
        end
    end

    // Read-cycle bus response, driven while synchronized E is high
    always_comb begin
        doe_nxt_s  = e_sync_r & rw_sync_r;
        dout_nxt_s = 8'h00;
        if (e_sync_r && rw_sync_r) begin
            if (rs_sync_r) dout_nxt_s = bus_rdata_s;
            else           dout_nxt_s = {busy_r, ac_r};
        end else begin
            dout_nxt_s = 8'h00;
        end
    end

    lcd_ddram u_ddram (
        .clk     (clk),
        .we      (mem_we_s),
        .waddr   (mem_waddr_s),
        .wdata   (mem_wdata_s),
        .raddr_a (ac_index(ac_r, cfg_r.n)),
        .rdata_a (bus_rdata_s),
        .raddr_b (view_addr),
        .rdata_b (view_char)
    );

    assign LCD_DOUT = dout_r;
    assign LCD_DOE  = doe_r;
    assign busy     = busy_r;
    assign ac       = ac_r;
    assign disp_on  = cfg_r.d;
    assign two_line = cfg_r.n;
    assign err      = err_r;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// ---------------------------------------------------------------------------
// tb_lcd_hd44780_responder
// Directed bench for lcd_hd44780_responder. Stimulus pushes expected values
// into queues; one monitor process pops and compares on the falling clock
// edge (state checks) and on each LCD_DOE assertion (read data).
// ---------------------------------------------------------------------------
module tb_lcd_hd44780_responder;

    localparam int SIG_AC    = 0;
    localparam int SIG_BUSY  = 1;
    localparam int SIG_DISP  = 2;
    localparam int SIG_TWO   = 3;
    localparam int SIG_ERR   = 4;
    localparam int SIG_VIEW  = 5;
    localparam int SIG_DOUT  = 6;
    localparam int SIG_DOE   = 7;
    localparam int SIG_MEAS  = 8;
    localparam int WAIT_MAX  = 300;

    typedef struct {
        string name;
        int    sig;
        int    exp;
        int    act;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       LCD_E, LCD_RS, LCD_RW;
    logic [7:0] LCD_DIN;
    logic [7:0] LCD_DOUT;
    logic       LCD_DOE;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, two_line, err;
    logic [6:0] view_addr;
    logic [7:0] view_char;

    chk_t sq[$];
    chk_t rq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic doe_q = 1'b0;

    always #5 clk = ~clk;

    lcd_hd44780_responder #(.BUSY_CYC(40), .CLR_BUSY_CYC(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DIN   (LCD_DIN),
        .LCD_DOUT  (LCD_DOUT),
        .LCD_DOE   (LCD_DOE),
        .busy      (busy),
        .ac        (ac),
        .disp_on   (disp_on),
        .two_line  (two_line),
        .err       (err),
        .view_addr (view_addr),
        .view_char (view_char)
    );

    function automatic int sample(input int sig, input int act);
        int r;
        case (sig)
            SIG_AC:   r = int'(ac);
            SIG_BUSY: r = int'(busy);
            SIG_DISP: r = int'(disp_on);
            SIG_TWO:  r = int'(two_line);
            SIG_ERR:  r = int'(err);
            SIG_VIEW: r = int'(view_char);
            SIG_DOUT: r = int'(LCD_DOUT);
            SIG_DOE:  r = int'(LCD_DOE);
            SIG_MEAS: r = act;
            default:  r = -1;
        endcase
        return r;
    endfunction

    // Monitor: drains state expectations and checks read data on DOE rise
    always @(negedge clk) begin
        chk_t c;
        int   a;
        while (sq.size() > 0) begin
            c = sq.pop_front();
            a = sample(c.sig, c.act);
            n_cmp = n_cmp + 1;
            if (a != c.exp) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, a, c.exp);
            end
        end
        if (LCD_DOE && !doe_q) begin
            n_cmp = n_cmp + 1;
            if (rq.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL unexpected_read: got DOUT 0x%0h, expected no read", LCD_DOUT);
            end else begin
                c = rq.pop_front();
                if (int'(LCD_DOUT) != c.exp) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, LCD_DOUT, c.exp);
                end
            end
        end
        doe_q <= LCD_DOE;
    end

    task automatic check(input string name, input int sig, input int exp, input int vaddr);
        view_addr = 7'(vaddr);
        sq.push_back('{name, sig, exp, 0});
        @(negedge clk);
        #1;
    endtask

    task automatic check_meas(input string name, input int act, input int exp);
        sq.push_back('{name, SIG_MEAS, exp, act});
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        LCD_RS = rs; LCD_RW = 1'b0; LCD_DIN = d; LCD_E = 1'b1;
        repeat (4) @(negedge clk);
        LCD_E = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input logic rs, input int exp);
        rq.push_back('{$sformatf("read_rs%0d", rs), SIG_DOUT, exp, 0});
        @(negedge clk);
        LCD_RS = rs; LCD_RW = 1'b1; LCD_DIN = 8'h00; LCD_E = 1'b1;
        repeat (4) @(negedge clk);
        LCD_E = 1'b0;
        repeat (4) @(negedge clk);
        LCD_RW = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy === 1'b1) && (n < WAIT_MAX)) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) check_meas("busy_timeout", 1, 0);
    endtask

    task automatic measure_busy(input string name, input int exp);
        int n;
        n = 0;
        while ((busy === 1'b1) && (n < WAIT_MAX)) begin
            @(negedge clk);
            n++;
        end
        check_meas(name, n, exp);
    endtask

    initial begin
        rst = 1'b0; LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0;
        LCD_DIN = 8'h00; view_addr = 7'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ac",   SIG_AC,   0, 0);
        check("rst_err",  SIG_ERR,  0, 0);
        check("rst_disp", SIG_DISP, 0, 0);
        check("rst_two",  SIG_TWO,  0, 0);
        check("rst_doe",  SIG_DOE,  0, 0);
        check("rst_dout", SIG_DOUT, 0, 0);

        // Power-on clear
        @(negedge clk); rst = 1'b1;
        measure_busy("init_busy_cycles", 100);
        for (int i = 0; i < 80; i++) check($sformatf("init_view%0d", i), SIG_VIEW, 8'h20, i);
        check("init_ac",   SIG_AC,   0, 0);
        check("init_disp", SIG_DISP, 0, 0);

        // Configure: 8-bit 2-line, display on, increment
        bus_write(1'b0, 8'h38); wait_idle();
        bus_write(1'b0, 8'h0C); wait_idle();
        bus_write(1'b0, 8'h06); wait_idle();
        check("cfg_two",  SIG_TWO,  1, 0);
        check("cfg_disp", SIG_DISP, 1, 0);
        check("cfg_ac",   SIG_AC,   0, 0);

        // Line 0 end wraps to line 1 start
        bus_write(1'b0, 8'hA7); wait_idle();
        check("setaddr_27", SIG_AC, 8'h27, 0);
        bus_write(1'b1, 8'h41); wait_idle();
        check("view39",     SIG_VIEW, 8'h41, 39);
        check("wrap_27_40", SIG_AC,   8'h40, 0);

        // Line 1 end wraps to 0x00
        bus_write(1'b0, 8'hE7); wait_idle();
        bus_write(1'b1, 8'h5A); wait_idle();
        check("view79",     SIG_VIEW, 8'h5A, 79);
        check("wrap_67_00", SIG_AC,   8'h00, 0);

        // Write while busy is dropped
        bus_write(1'b0, 8'h85); wait_idle();
        bus_write(1'b1, 8'h31);
        repeat (5) @(negedge clk);
        bus_write(1'b1, 8'h31);
        check("drop_view5", SIG_VIEW, 8'h31, 5);
        check("drop_view6", SIG_VIEW, 8'h20, 6);
        check("drop_ac",    SIG_AC,   8'h06, 0);
        check("drop_err",   SIG_ERR,  1, 0);
        wait_idle();

        // Data read steps AC; status read returns {busy, AC}
        bus_write(1'b0, 8'h85); wait_idle();
        bus_read(1'b1, 8'h31);
        check("read_step_ac", SIG_AC, 8'h06, 0);
        bus_read(1'b0, 8'h06);

        // Reset pulsed at fill index 30 restarts the whole clear
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        measure_busy("reclear_busy_cycles", 100);
        check("reclear_ac",  SIG_AC,  0, 0);
        check("reclear_err", SIG_ERR, 0, 0);
        check("reclear_two", SIG_TWO, 0, 0);
        for (int i = 0; i < 80; i++) check($sformatf("reclear_view%0d", i), SIG_VIEW, 8'h20, i);

        // 1-line decrement wraps 0x00 -> 0x4F
        bus_write(1'b0, 8'h04); wait_idle();
        bus_write(1'b0, 8'h80); wait_idle();
        bus_write(1'b1, 8'h77); wait_idle();
        check("dec_wrap_ac", SIG_AC,   8'h4F, 0);
        check("dec_view0",   SIG_VIEW, 8'h77, 0);

        // Clear instruction: status read shows busy, then blank, AC=0, I/D=1
        bus_write(1'b0, 8'h01);
        bus_read(1'b0, 8'h80);
        wait_idle();
        check("clr_view0", SIG_VIEW, 8'h20, 0);
        check("clr_ac",    SIG_AC,   0, 0);
        bus_write(1'b1, 8'h11); wait_idle();
        check("clr_id_ac",  SIG_AC,   1, 0);
        check("post_view0", SIG_VIEW, 8'h11, 0);

        // Invalid set-address in 1-line mode
        bus_write(1'b0, 8'hD0); wait_idle();
        check("bad_addr_err", SIG_ERR, 1, 0);
        check("bad_addr_ac",  SIG_AC,  1, 0);

        check_meas("reads_pending", rq.size(), 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
